axi_burst_read_master: RTL and testbench

- AXI4 read initiator for the 512-bit memory port. It is the master-side counterpart of the axi_ram responder.
- It takes a (start address, beat count) command and splits it into INCR bursts. Bursts never exceed MAX_BURST_LEN and never cross a 4 KB boundary.
- It streams the returned beats out on a valid/ready interface.
- Used by the accelerator's feature-map and weight loaders to pull data from DDR/axi_ram.

---
 rtl/axi_burst_read_master.sv | 177 +++++++++++++++++
 tb/tb_axi_burst_read_master.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_read_master.sv
// rtl/axi_burst_read_master.sv - AXI4 INCR burst read initiator with streamed beat output
// Optional rresp/rlast checking is compiled in with `define READ_RESP_CHECK_EN.
module axi_burst_read_master #(
   parameter int DATA_WIDTH    = 512,
   parameter int ADDR_WIDTH    = 32,
   parameter int MAX_BURST_LEN = 16,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                  system_clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [CNT_WIDTH-1:0]  cmd_beats,
   output logic [7:0]            m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arlock,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int BEAT_BYTES = DATA_WIDTH / 8;
   localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BEAT_BYTES - 1);

   typedef enum logic [2:0] {IDLE, CALC, ADDR, DATA, DONE} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [CNT_WIDTH-1:0]    remaining_r;
   logic [8:0]              len_r;
   logic [8:0]              beat_cnt_r;
   logic [8:0]              len_next;
   logic [12:0]             bytes_to_4k;
   logic [12:0]             beats_to_4k;
   logic                    cmd_fire;
   logic                    ar_fire;
   logic                    beat_fire;
   logic                    burst_last_beat;
   logic                    burst_end;

   assign m_axi_arid    = 8'd0;
   assign m_axi_arsize  = 3'd6;
   assign m_axi_arburst = 2'b01;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'b0011;
   assign m_axi_arprot  = 3'd0;
   assign out_data      = m_axi_rdata;

   assign cmd_fire        = cmd_valid && cmd_ready;
   assign ar_fire         = m_axi_arvalid && m_axi_arready;
   assign beat_fire       = m_axi_rvalid && m_axi_rready;
   assign burst_last_beat = (beat_cnt_r == len_r - 9'd1);
   assign burst_end       = beat_fire && burst_last_beat;

   // Bytes left before the next 4 KB page; the address is always beat aligned.
   assign bytes_to_4k = 13'h1000 - {1'b0, addr_r[11:0]};
   assign beats_to_4k = bytes_to_4k >> BEAT_SHIFT;

   // Burst length: smallest of remaining beats, max burst and beats to the 4 KB page end.
   always_comb begin
      len_next = 9'(MAX_BURST_LEN);
      if (32'(remaining_r) < 32'(len_next)) len_next = 9'(remaining_r);
      if (32'(beats_to_4k) < 32'(len_next)) len_next = 9'(beats_to_4k);
   end

   // State register.
   always_ff @(posedge system_clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; bursts end on the beat counter, never on rlast.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (cmd_fire) state_nxt = (cmd_beats == '0) ? DONE : CALC;
         CALC: state_nxt = ADDR;
         ADDR: if (ar_fire) state_nxt = DATA;
         DATA: if (burst_end) state_nxt = (remaining_r != '0) ? CALC : DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State-decoded outputs; the R channel is a combinational pass-through in DATA.
   always_comb begin
      cmd_ready     = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      out_valid     = 1'b0;
      out_last      = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      case (state)
         IDLE: cmd_ready = 1'b1;
         CALC: busy = 1'b1;
         ADDR: begin
            busy          = 1'b1;
            m_axi_arvalid = 1'b1;
         end
         DATA: begin
            busy         = 1'b1;
            m_axi_rready = out_ready;
            out_valid    = m_axi_rvalid;
            out_last     = m_axi_rvalid && (remaining_r == '0) && burst_last_beat;
         end
         DONE: done = 1'b1;
         default: ;
      endcase
   end

   // Address, remaining-beat and per-burst beat bookkeeping.
   always_ff @(posedge system_clk) begin
      if (rst) begin
         addr_r       <= '0;
         remaining_r  <= '0;
         len_r        <= '0;
         beat_cnt_r   <= '0;
         m_axi_araddr <= '0;
         m_axi_arlen  <= '0;
      end else begin
         if (cmd_fire) begin
            addr_r      <= cmd_addr & ALIGN_MASK;
            remaining_r <= cmd_beats;
            beat_cnt_r  <= '0;
         end
         if (state == CALC) begin
            len_r        <= len_next;
            m_axi_araddr <= addr_r;
            m_axi_arlen  <= 8'(len_next - 9'd1);
         end
         if (ar_fire) begin
            addr_r      <= addr_r + (ADDR_WIDTH'(len_r) << BEAT_SHIFT);
            remaining_r <= remaining_r - CNT_WIDTH'(len_r);
         end
         if (beat_fire) beat_cnt_r <= burst_last_beat ? 9'd0 : beat_cnt_r + 9'd1;
      end
   end

`ifdef READ_RESP_CHECK_EN
   logic err_r;

   // Sticky error on a bad response or an rlast that disagrees with the beat counter.
   always_ff @(posedge system_clk) begin
      if (rst)           err_r <= 1'b0;
      else if (cmd_fire) err_r <= 1'b0;
      else if (beat_fire && ((m_axi_rresp != 2'b00) || (m_axi_rlast != burst_last_beat)))
         err_r <= 1'b1;
   end

   assign err = err_r;
`else
   logic unused_resp;
   assign unused_resp = ^{m_axi_rresp, m_axi_rlast};
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_burst_read_master.sv
// tb/tb_axi_burst_read_master.sv - directed table-driven bench for axi_burst_read_master
module tb_axi_burst_read_master;

   localparam int DW = 512;
   localparam int AW = 32;

   logic          system_clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr;
   logic [15:0]   cmd_beats;
   logic [7:0]    m_axi_arid;
   logic [AW-1:0] m_axi_araddr;
   logic [7:0]    m_axi_arlen;
   logic [2:0]    m_axi_arsize;
   logic [1:0]    m_axi_arburst;
   logic          m_axi_arlock;
   logic [3:0]    m_axi_arcache;
   logic [2:0]    m_axi_arprot;
   logic          m_axi_arvalid;
   logic          m_axi_arready;
   logic [DW-1:0] m_axi_rdata;
   logic [1:0]    m_axi_rresp;
   logic          m_axi_rlast;
   logic          m_axi_rvalid;
   logic          m_axi_rready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          err;

   axi_burst_read_master dut (
      .system_clk(system_clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
      .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .busy(busy), .done(done), .err(err)
   );

   always #5 system_clk = ~system_clk;

   typedef struct packed {
      logic [31:0]      addr;
      logic [15:0]      beats;
      logic [3:0]       ar_delay;
      logic             toggle;
      logic [1:0]       n_ar;
      logic [2:0][31:0] ar_addr;
      logic [2:0][7:0]  ar_len;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   // responder / consumer / monitor state
   int          ncyc = 0;
   int          ar_delay = 0;
   int          ar_hold = 0;
   logic        toggle = 1'b0;
   logic        hold_ready = 1'b0;
   logic        have_burst = 1'b0;
   logic [31:0] b_addr = '0;
   int          b_len = 0;
   int          b_beat = 0;
   int          r_idx = 0;
   int          err_idx = -1;
   logic [31:0] beat_addr;
   logic        arv_pend = 1'b0;
   logic [31:0] pend_addr = '0;
   logic [7:0]  pend_len = '0;
   int          stab_err = 0;
   int          done_cnt = 0;
   int          done_cyc = -1;
   int          accept_cyc = -1;
   int          first_arv_cyc = -1;
   logic [31:0] ara_q[$];
   logic [7:0]  arl_q[$];
   logic [DW-1:0] beat_q[$];
   logic        last_q[$];

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic [31:0] a, input logic [15:0] n, input logic [3:0] dly,
                                input logic tog, input logic [1:0] nar,
                                input logic [31:0] a0, input logic [7:0] l0,
                                input logic [31:0] a1, input logic [7:0] l1,
                                input logic [31:0] a2, input logic [7:0] l2);
      vec_t v;
      v.addr = a; v.beats = n; v.ar_delay = dly; v.toggle = tog; v.n_ar = nar;
      v.ar_addr[0] = a0; v.ar_len[0] = l0;
      v.ar_addr[1] = a1; v.ar_len[1] = l1;
      v.ar_addr[2] = a2; v.ar_len[2] = l2;
      return v;
   endfunction

   // Responder drives at negedge; handshakes are sampled 1 time unit later, before the posedge.
   initial begin
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
      m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; out_ready = 1'b0;
      forever begin
         @(negedge system_clk);
         ncyc++;
         m_axi_arready = m_axi_arvalid && (ar_hold >= ar_delay);
         m_axi_rvalid  = have_burst;
         beat_addr     = b_addr + 32'(b_beat * 64);
         m_axi_rdata   = {16{beat_addr}};
         m_axi_rlast   = have_burst && (b_beat == b_len - 1);
         m_axi_rresp   = (have_burst && r_idx == err_idx) ? 2'b10 : 2'b00;
         out_ready     = hold_ready ? 1'b0 : (toggle ? ncyc[0] : 1'b1);
         #1;
         if (rst) begin
            have_burst = 1'b0; ar_hold = 0; arv_pend = 1'b0;
         end else begin
            if (cmd_valid && cmd_ready) accept_cyc = ncyc;
            if (done) begin done_cnt++; done_cyc = ncyc; end
            if (m_axi_arvalid && first_arv_cyc < 0) first_arv_cyc = ncyc;
            if (m_axi_arvalid && arv_pend && (m_axi_araddr != pend_addr || m_axi_arlen != pend_len))
               stab_err++;
            arv_pend  = m_axi_arvalid && !m_axi_arready;
            pend_addr = m_axi_araddr;
            pend_len  = m_axi_arlen;
            ar_hold   = (m_axi_arvalid && !m_axi_arready) ? ar_hold + 1 : 0;
            if (out_valid && out_ready) begin
               beat_q.push_back(out_data);
               last_q.push_back(out_last);
            end
            if (m_axi_rvalid && m_axi_rready) begin
               b_beat++; r_idx++;
               if (b_beat == b_len) have_burst = 1'b0;
            end
            if (m_axi_arvalid && m_axi_arready) begin
               ara_q.push_back(m_axi_araddr);
               arl_q.push_back(m_axi_arlen);
               have_burst = 1'b1; b_addr = m_axi_araddr;
               b_len = int'(m_axi_arlen) + 1; b_beat = 0;
            end
         end
      end
   end

   task automatic clear_mon();
      ara_q.delete(); arl_q.delete(); beat_q.delete(); last_q.delete();
      done_cnt = 0; done_cyc = -1; accept_cyc = -1; first_arv_cyc = -1;
      stab_err = 0; r_idx = 0;
   endtask

   task automatic run_vec(input vec_t v, input int eidx, input logic exp_err);
      logic [31:0] base;
      int d;
      @(negedge system_clk);
      clear_mon();
      ar_delay = int'(v.ar_delay); toggle = v.toggle; err_idx = eidx;
      cmd_valid = 1'b1; cmd_addr = v.addr; cmd_beats = v.beats;
      @(negedge system_clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (done_cnt != 0) break;
         @(negedge system_clk);
      end
      repeat (3) @(negedge system_clk);
      #2;
      chk("done_count", 64'(done_cnt), 64'd1);
      chk("ar_count", 64'(ara_q.size()), 64'(v.n_ar));
      for (int i = 0; i < int'(v.n_ar); i++) begin
         if (i < ara_q.size()) begin
            chk("araddr", 64'(ara_q[i]), 64'(v.ar_addr[i]));
            chk("arlen", 64'(arl_q[i]), 64'(v.ar_len[i]));
         end
      end
      chk("beat_count", 64'(beat_q.size()), 64'(v.beats));
      base = v.addr & 32'hFFFF_FFC0;
      for (int i = 0; i < int'(v.beats); i++) begin
         if (i < beat_q.size()) begin
            chk_data("beat_data", beat_q[i], {16{base + 32'(i * 64)}});
            chk("out_last", 64'(last_q[i]), 64'(i == int'(v.beats) - 1));
         end
      end
      chk("araddr_stable", 64'(stab_err), 64'd0);
      chk("err", 64'(err), 64'(exp_err));
      chk("busy_after", 64'(busy), 64'd0);
      chk("cmd_ready_after", 64'(cmd_ready), 64'd1);
      if (v.beats != 0) begin
         chk("arvalid_latency", 64'(first_arv_cyc - accept_cyc), 64'd2);
      end else begin
         d = done_cyc - accept_cyc;
         chk("zero_no_arvalid", 64'(first_arv_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
         chk("zero_done_latency", 64'(d >= 1 && d <= 2), 64'd1);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
      chk({tag, "_arvalid"}, 64'(m_axi_arvalid), 64'd0);
      chk({tag, "_araddr"}, 64'(m_axi_araddr), 64'd0);
      chk({tag, "_arlen"}, 64'(m_axi_arlen), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_err"}, 64'(err), 64'd0);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_out_last"}, 64'(out_last), 64'd0);
      chk({tag, "_rready"}, 64'(m_axi_rready), 64'd0);
   endtask

   initial begin
      logic exp_bad;
      rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
      vecs[0] = mkv(32'h0000_1000, 16'd4,  4'd0, 1'b0, 2'd1, 32'h1000, 8'd3, 32'h0, 8'd0, 32'h0, 8'd0);
      vecs[1] = mkv(32'h0000_0FC0, 16'd3,  4'd0, 1'b0, 2'd2, 32'h0FC0, 8'd0, 32'h1000, 8'd1, 32'h0, 8'd0);
      vecs[2] = mkv(32'h0000_0000, 16'd40, 4'd0, 1'b0, 2'd3, 32'h0000, 8'd15, 32'h0400, 8'd15, 32'h0800, 8'd7);
      vecs[3] = mkv(32'h0000_2000, 16'd8,  4'd3, 1'b1, 2'd1, 32'h2000, 8'd7, 32'h0, 8'd0, 32'h0, 8'd0);
      vecs[4] = mkv(32'h0000_1F3F, 16'd2,  4'd1, 1'b0, 2'd1, 32'h1F00, 8'd1, 32'h0, 8'd0, 32'h0, 8'd0);
      vecs[5] = mkv(32'h0000_5000, 16'd0,  4'd0, 1'b0, 2'd0, 32'h0, 8'd0, 32'h0, 8'd0, 32'h0, 8'd0);
      vecs[6] = mkv(32'hFFFF_FFC0, 16'd2,  4'd0, 1'b1, 2'd2, 32'hFFFF_FFC0, 8'd0, 32'h0, 8'd0, 32'h0, 8'd0);
      vecs[7] = mkv(32'h0000_6000, 16'd16, 4'd2, 1'b0, 2'd1, 32'h6000, 8'd15, 32'h0, 8'd0, 32'h0, 8'd0);

      repeat (3) @(negedge system_clk);
      #2;
      chk_reset_outputs("reset");
      chk("arsize", 64'(m_axi_arsize), 64'd6);
      chk("arburst", 64'(m_axi_arburst), 64'd1);
      chk("arcache", 64'(m_axi_arcache), 64'd3);
      chk("arid", 64'(m_axi_arid), 64'd0);
      @(negedge system_clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run_vec(vecs[i], -1, 1'b0);

`ifdef READ_RESP_CHECK_EN
      exp_bad = 1'b1;
`else
      exp_bad = 1'b0;
`endif
      // rresp error on the second beat; err must survive done, then clear on next accept
      run_vec(mkv(32'h0000_3000, 16'd4, 4'd0, 1'b0, 2'd1, 32'h3000, 8'd3, 32'h0, 8'd0, 32'h0, 8'd0),
              1, exp_bad);
      repeat (2) @(negedge system_clk);
      #2;
      chk("err_sticky_idle", 64'(err), 64'(exp_bad));
      run_vec(vecs[5], -1, 1'b0);

      // reset while stalled in DATA
      @(negedge system_clk);
      clear_mon();
      ar_delay = 0; toggle = 1'b0; err_idx = -1; hold_ready = 1'b1;
      cmd_valid = 1'b1; cmd_addr = 32'h4000; cmd_beats = 16'd8;
      @(negedge system_clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (have_burst) break;
         @(negedge system_clk);
      end
      chk("reached_data", 64'(have_burst), 64'd1);
      @(negedge system_clk);
      #2;
      chk("stalled_out_valid", 64'(out_valid), 64'd1);
      @(negedge system_clk);
      rst = 1'b1;
      @(negedge system_clk);
      #2;
      chk_reset_outputs("midreset");
      chk("midreset_no_beats", 64'(beat_q.size()), 64'd0);
      rst = 1'b0; hold_ready = 1'b0;
      run_vec(vecs[0], -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
